// File: rtl/adc_result_fifo_if.sv
// adc_result_fifo_if -- bundle of the SAR result handshake, FIFO control and
// status signals between a producer/consumer (master) and the FIFO (slave).
//   conv_finished_in / result_in : conversion-done level and result word
//   rd_en_in, flush_in, clr_ovf_in, threshold_in : consumer controls
//   data_out, valid_out, full_out, level_out, overflow_out, irq_out : status
interface adc_result_fifo_if #(
  parameter int DATA_BITS  = 12,
  parameter int DEPTH_LOG2 = 3
);
  logic                  conv_finished_in;
  logic [DATA_BITS-1:0]  result_in;
  logic                  rd_en_in;
  logic                  flush_in;
  logic                  clr_ovf_in;
  logic [DEPTH_LOG2:0]   threshold_in;
  logic [DATA_BITS-1:0]  data_out;
  logic                  valid_out;
  logic                  full_out;
  logic [DEPTH_LOG2:0]   level_out;
  logic                  overflow_out;
  logic                  irq_out;

  modport master (
    output conv_finished_in, result_in, rd_en_in, flush_in, clr_ovf_in, threshold_in,
    input  data_out, valid_out, full_out, level_out, overflow_out, irq_out
  );

  modport slave (
    input  conv_finished_in, result_in, rd_en_in, flush_in, clr_ovf_in, threshold_in,
    output data_out, valid_out, full_out, level_out, overflow_out, irq_out
  );
endinterface

// File: rtl/adc_result_fifo.sv
// adc_result_fifo -- first-word fall-through FIFO capturing SAR conversion
// results on the rising edge of the conversion-done level.
//   clk   : system clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : adc_result_fifo_if.slave (write strobe/data, pop, flush,
//           overflow clear, irq threshold; head data and status flags)
module adc_result_fifo #(
  parameter int DATA_BITS  = 12,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  adc_result_fifo_if.slave   bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LVL_W = DEPTH_LOG2 + 1;

  logic [DATA_BITS-1:0]  r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [LVL_W-1:0]      r_level;
  logic                  r_conv_d;
  logic                  r_ovf;

  logic w_wr_evt;
  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_wr_ok;
  logic w_ovf_evt;

  assign w_wr_evt  = bus.conv_finished_in & ~r_conv_d;
  assign w_full    = (r_level == LVL_W'(DEPTH));
  assign w_empty   = (r_level == '0);
  // Flush discards both the pop and the write of the same cycle.
  assign w_pop     = bus.rd_en_in & ~w_empty & ~bus.flush_in;
  // A full FIFO still accepts a write when the head is popped in the same cycle.
  assign w_wr_ok   = w_wr_evt & ~bus.flush_in & (~w_full | w_pop);
  assign w_ovf_evt = w_wr_evt & ~bus.flush_in & w_full & ~w_pop;

  // Storage is not reset; data_out is masked while empty.
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wr_ptr] <= bus.result_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conv_d <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_conv_d <= bus.conv_finished_in;
      if (bus.flush_in) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
      end else begin
        if (w_wr_ok) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
        if (w_pop)   r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
        case ({w_wr_ok, w_pop})
          2'b10:   r_level <= r_level + LVL_W'(1);
          2'b01:   r_level <= r_level - LVL_W'(1);
          default: r_level <= r_level;
        endcase
      end
      // Set wins over a same-cycle clear.
      if (w_ovf_evt)           r_ovf <= 1'b1;
      else if (bus.clr_ovf_in) r_ovf <= 1'b0;
    end
  end

  assign bus.data_out     = w_empty ? '0 : r_mem[r_rd_ptr];
  assign bus.valid_out    = ~w_empty;
  assign bus.full_out     = w_full;
  assign bus.level_out    = r_level;
  assign bus.overflow_out = r_ovf;
  // Level never exceeds DEPTH, so thresholds above DEPTH never fire.
  assign bus.irq_out      = (bus.threshold_in != '0) && (r_level >= bus.threshold_in);
endmodule

// File: tb/tb_adc_result_fifo.sv
module tb_adc_result_fifo;
  localparam int DATA_BITS  = 12;
  localparam int DEPTH_LOG2 = 3;
  localparam int DEPTH      = 8;

  logic clk;
  logic rst_n;

  adc_result_fifo_if #(.DATA_BITS(DATA_BITS), .DEPTH_LOG2(DEPTH_LOG2)) bus ();

  adc_result_fifo #(.DATA_BITS(DATA_BITS), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_BITS-1:0] sb_q[$];
  bit                   m_ovf  = 1'b0;
  bit                   m_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic check_outputs(input string ctx);
    int sz;
    bit irq_exp;
    sz = sb_q.size();
    irq_exp = (bus.threshold_in != 0) && (sz >= int'(bus.threshold_in));
    chk({ctx, ".level"}, 32'(bus.level_out), 32'(sz));
    chk({ctx, ".valid"}, 32'(bus.valid_out), 32'(sz > 0));
    chk({ctx, ".full"},  32'(bus.full_out),  32'(sz == DEPTH));
    chk({ctx, ".ovf"},   32'(bus.overflow_out), 32'(m_ovf));
    chk({ctx, ".irq"},   32'(bus.irq_out),   32'(irq_exp));
    chk({ctx, ".data"},  32'(bus.data_out),  (sz > 0) ? 32'(sb_q[0]) : 32'd0);
  endtask

  // One clock cycle: drive inputs, update the model, compare after the edge.
  task automatic cycle(input string ctx, input bit wr, input logic [DATA_BITS-1:0] d,
                       input bit rd, input bit fl, input bit clr);
    bit evt, pop, ovf_evt;
    int sz;
    bus.conv_finished_in = wr;
    bus.result_in        = d;
    bus.rd_en_in         = rd;
    bus.flush_in         = fl;
    bus.clr_ovf_in       = clr;
    #1;
    evt     = wr && !m_prev;
    sz      = sb_q.size();
    pop     = rd && (sz > 0) && !fl;
    ovf_evt = 1'b0;
    if (pop) begin
      chk({ctx, ".pop_data"}, 32'(bus.data_out), 32'(sb_q[0]));
      void'(sb_q.pop_front());
    end
    if (fl) sb_q.delete();
    else if (evt) begin
      if (sz < DEPTH || pop) sb_q.push_back(d);
      else ovf_evt = 1'b1;
    end
    if (ovf_evt) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    m_prev = wr;
    @(posedge clk);
    #1;
    check_outputs(ctx);
  endtask

  task automatic pulse_write(input string ctx, input logic [DATA_BITS-1:0] d);
    cycle(ctx, 1'b1, d, 1'b0, 1'b0, 1'b0);
    cycle(ctx, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain(input string ctx);
    for (int k = 0; k < 2 * DEPTH && sb_q.size() > 0; k++)
      cycle(ctx, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk({ctx, ".drained"}, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic check_all_zero(input string ctx);
    chk({ctx, ".data"},  32'(bus.data_out), 32'd0);
    chk({ctx, ".valid"}, 32'(bus.valid_out), 32'd0);
    chk({ctx, ".full"},  32'(bus.full_out), 32'd0);
    chk({ctx, ".level"}, 32'(bus.level_out), 32'd0);
    chk({ctx, ".ovf"},   32'(bus.overflow_out), 32'd0);
    chk({ctx, ".irq"},   32'(bus.irq_out), 32'd0);
  endtask

  logic [DATA_BITS-1:0] seq_vals [12];

  initial begin
    seq_vals = '{12'd806, 12'd13, 12'd489, 12'd4095, 12'd0, 12'd1, 12'd2730,
                 12'd1365, 12'd77, 12'd3000, 12'd512, 12'd999};
    rst_n = 1'b1;
    bus.conv_finished_in = 1'b0;
    bus.result_in    = '0;
    bus.rd_en_in     = 1'b0;
    bus.flush_in     = 1'b0;
    bus.clr_ovf_in   = 1'b0;
    bus.threshold_in = '0;
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset_hold");
    rst_n = 1'b1;

    // Single capture and pop
    pulse_write("single", 12'd2048);
    chk("single.data2048", 32'(bus.data_out), 32'd2048);
    cycle("single_pop", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    // Pop while empty is ignored
    cycle("empty_pop", 1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Ordering across pointer wrap with interleaved pops
    for (int i = 0; i < 12; i++) begin
      cycle("order_w", 1'b1, seq_vals[i], (i % 2) == 1, 1'b0, 1'b0);
      cycle("order_i", 1'b0, '0, (i % 3) == 0, 1'b0, 1'b0);
    end
    drain("order_drain");

    // Empty with simultaneous write and pop
    cycle("empty_wr_rd", 1'b1, 12'd321, 1'b1, 1'b0, 1'b0);
    cycle("empty_wr_rd2", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    drain("ewr_drain");

    // Overflow: nine writes, no pops
    for (int i = 0; i < 9; i++) pulse_write("ovf_fill", DATA_BITS'(100 + i));
    chk("ovf.sticky", 32'(bus.overflow_out), 32'd1);
    drain("ovf_drain");
    cycle("ovf_clr", 1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Full with simultaneous write and pop
    for (int i = 0; i < 8; i++) pulse_write("fwp_fill", DATA_BITS'(200 + i));
    cycle("fwp", 1'b1, 12'd3333, 1'b1, 1'b0, 1'b0);
    cycle("fwp2", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    // Overflow and clear in the same cycle: set wins
    cycle("ovf_setclr", 1'b1, 12'd1, 1'b0, 1'b0, 1'b1);
    cycle("ovf_setclr2", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    // Flush with a same-cycle write keeps the overflow flag
    cycle("flush", 1'b1, 12'd55, 1'b1, 1'b1, 1'b0);
    cycle("flush2", 1'b0, '0, 1'b0, 1'b0, 1'b1);

    // Threshold interrupt
    bus.threshold_in = 4'd4;
    for (int i = 0; i < 5; i++) pulse_write("thr4_fill", DATA_BITS'(300 + i));
    cycle("thr4_pop", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    cycle("thr4_pop", 1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) pulse_write("thr4_refill", DATA_BITS'(400 + i));
    bus.threshold_in = 4'd0;
    #1 check_outputs("thr0_full");
    bus.threshold_in = 4'd8;
    #1 check_outputs("thr8_full");
    bus.threshold_in = 4'd9;
    #1 check_outputs("thr9_full");
    bus.threshold_in = 4'd15;
    #1 check_outputs("thr15_full");
    bus.threshold_in = 4'd0;
    drain("thr_drain");

    // Held-high conversion-done gives one write
    for (int i = 0; i < 20; i++) cycle("hold", 1'b1, DATA_BITS'(500 + i), 1'b0, 1'b0, 1'b0);
    cycle("hold_end", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("hold.level", 32'(bus.level_out), 32'd1);

    // Asynchronous reset at level 5
    for (int i = 0; i < 4; i++) pulse_write("rst_fill", DATA_BITS'(600 + i));
    chk("rst_fill.level", 32'(bus.level_out), 32'd5);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    sb_q.delete();
    m_ovf  = 1'b0;
    m_prev = 1'b0;
    bus.conv_finished_in = 1'b1;
    bus.result_in = 12'd777;
    repeat (2) @(posedge clk);
    #1 check_all_zero("rst_hold");
    rst_n = 1'b1;
    // Conversion-done already high at release writes once
    cycle("rel_write", 1'b1, 12'd777, 1'b0, 1'b0, 1'b0);
    cycle("rel_hold", 1'b1, 12'd778, 1'b0, 1'b0, 1'b0);
    cycle("rel_low", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    drain("final_drain");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/adc_result_fifo.md
ADC_RESULT_FIFO -- requirements
Module: adc_result_fifo

Interface
REQ-001 Parameter DATA_BITS, default 12, result word width; matches the SAR controller result width.
REQ-002 Parameter DEPTH_LOG2, default 3, log2 of FIFO depth, giving 8 entries at default.
REQ-003 clk  input  1  single clock domain, shared with the SAR controller; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 conv_finished_in  input  1  conversion-done level from the SAR controller; rising edge marks a new result.
REQ-006 result_in  input  DATA_BITS  conversion result, stable while conv_finished_in is high.
REQ-007 rd_en_in  input  1  pop request for the head entry.
REQ-008 flush_in  input  1  synchronous FIFO clear.
REQ-009 clr_ovf_in  input  1  clears the sticky overflow flag.
REQ-010 threshold_in  input  DEPTH_LOG2+1  fill level that raises irq_out; 0 disables irq_out.
REQ-011 data_out  output  DATA_BITS  head entry (first-word fall-through).
REQ-012 valid_out  output  1  FIFO not empty.
REQ-013 full_out  output  1  level equals 2^DEPTH_LOG2.
REQ-014 level_out  output  DEPTH_LOG2+1  number of stored entries, 0..2^DEPTH_LOG2.
REQ-015 overflow_out  output  1  sticky: at least one result was dropped.
REQ-016 irq_out  output  1  fill-level interrupt.

Function
REQ-017 Edge detect: register conv_finished_in once; a write event occurs in cycle N when conv_finished_in=1 and the registered copy=0.
REQ-018 A held-high conv_finished_in produces exactly one write; a new write requires a low cycle first.
REQ-019 Write: result_in sampled in cycle N is stored at wr_ptr on the clock edge ending cycle N.
REQ-020 Write latency: the word appears on data_out, with valid_out=1, in cycle N+1 when the FIFO was empty.
REQ-021 data_out shall equal mem[rd_ptr] when valid_out=1 and shall be 0 when valid_out=0.
REQ-022 Pop: rd_en_in=1 with valid_out=1 advances rd_ptr at the clock edge; rd_en_in while empty is ignored with no pointer or level change.
REQ-023 Pointers are DEPTH_LOG2 bits and wrap modulo 2^DEPTH_LOG2.
REQ-024 level_out changes by +1 on write only, -1 on pop only, and 0 on a simultaneous write and pop.
REQ-025 Full without a pop: the write is dropped, memory, pointers and level are unchanged, and overflow_out is set on the next edge.
REQ-026 Full with a simultaneous pop: both operations succeed, level stays 2^DEPTH_LOG2, and no overflow occurs.
REQ-027 Empty with a simultaneous write and rd_en_in: the write succeeds and the pop is ignored, giving level 1.
REQ-028 flush_in=1 clears pointers and level next edge, has priority over any same-cycle write or pop (the write is discarded), and does not change overflow_out.
REQ-029 overflow_out stays 1 until clr_ovf_in=1; a same-cycle overflow event and clear leaves overflow_out=1 (set wins).
REQ-030 irq_out = (threshold_in != 0) AND (level_out >= threshold_in), decoded combinationally from registered level.
REQ-031 threshold_in values above 2^DEPTH_LOG2 shall never assert irq_out.

Reset
REQ-032 Asserting rst_n=0 immediately clears pointers, level, overflow and the edge-detect register, regardless of clk.
REQ-033 During reset: data_out=0, valid_out=0, full_out=0, level_out=0, overflow_out=0, irq_out=0.
REQ-034 Reset mid-operation discards all stored entries.
REQ-035 If conv_finished_in is already high when rst_n releases, a write occurs in the first cycle after release, since the edge-detect register resets to 0.
REQ-036 Memory contents need no reset; REQ-021 masks stale data.

Verification
REQ-037 Single capture: result_in=2048, pulse conv_finished_in -> next cycle data_out=2048, valid_out=1, level_out=1; pop -> valid_out=0, data_out=0.
REQ-038 Ordering and wrap: write 806, 13, 489, 4095, 0 with pops interleaved, 12 writes total -> read order matches write order across the pointer wrap.
REQ-039 Overflow: 9 writes with no pops -> full_out=1 from write 8, the 9th is dropped and overflow_out=1; pop 8 entries -> the first 8 values come out; clr_ovf_in -> overflow_out=0.
REQ-040 Full plus simultaneous write and pop -> level_out stays 8, overflow_out=0, the head advances, and the new word becomes the tail.
REQ-041 Threshold: threshold_in=4 -> irq_out rises on the edge where level_out becomes 4 and drops when a pop brings it to 3; threshold_in=0 -> irq_out stays 0 at level 8.
REQ-042 Hold and reset: conv_finished_in held high for 20 cycles -> exactly one write; rst_n pulsed low at level 5 -> all outputs 0 asynchronously, FIFO empty after release.
